xorshift_rng_bank: RTL and testbench

XORSHIFT_RNG_BANK -- requirements
Module: xorshift_rng_bank

---
 rtl/xorshift_pkg.sv | 30 +++
 rtl/xorshift32_next.sv | 11 +
 rtl/xorshift_rng_bank.sv | 106 ++++++++++
 tb/tb_xorshift_rng_bank.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xorshift_pkg.sv
// Shared constants, FSM state type and the xorshift32 step / lane-seed helpers
// used by the RNG bank and its per-lane next-state logic.
package xorshift_pkg;

    localparam int          SHIFT_A = 13;
    localparam int          SHIFT_B = 17;
    localparam int          SHIFT_C = 5;
    localparam logic [31:0] GOLDEN  = 32'h9E3779B9;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] a;
        logic [31:0] b;
        a = x ^ (x << SHIFT_A);
        b = a ^ (a >> SHIFT_B);
        return b ^ (b << SHIFT_C);
    endfunction

    // Zero is a fixed point of xorshift, so a lane must never be seeded with it.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input logic [31:0] idx);
        logic [31:0] r;
        r = base ^ (idx * GOLDEN);
        return (r == 32'h0) ? 32'h0000_0001 : r;
    endfunction

endpackage

// File: rtl/xorshift32_next.sv
// Combinational xorshift32 step for one lane.
module xorshift32_next
    import xorshift_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    assign y = xs_step(x);

endmodule

// File: rtl/xorshift_rng_bank.sv
// Bank of independent xorshift32 lanes with warm-up after reset/reseed and a
// valid/ready output register holding one word per lane.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_WARMUP | lanes step every cycle, output discarded, WARMUP cycles total
//  ST_RUN    | lanes step only when the output register is (re)loaded
module xorshift_rng_bank
    import xorshift_pkg::*;
#(
    parameter int          N_LANES = 4,
    parameter logic [31:0] SEED    = 32'h8e20a6e5,
    parameter int          WARMUP  = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_we,
    input  logic [31:0]            seed_in,
    input  logic                   rnd_ready,
    output logic                   rnd_valid,
    output logic [32*N_LANES-1:0]  rnd_out,
    output logic                   warming
);

    localparam logic [7:0] CNT_LAST = 8'(WARMUP - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       valid_nx;
    logic       load;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        valid_nx = rnd_valid;
        load     = 1'b0;
        case (state)
            ST_WARMUP: begin
                cnt_nx = cnt + 8'd1;
                if (cnt == CNT_LAST) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                load = !rnd_valid || rnd_ready;
                if (load) begin
                    valid_nx = 1'b1;
                end
            end
        endcase
        // A reseed restarts warm-up and drops any pending word, even mid-transfer.
        if (seed_we) begin
            state_nx = ST_WARMUP;
            cnt_nx   = 8'd0;
            valid_nx = 1'b0;
            load     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WARMUP;
            cnt       <= 8'd0;
            rnd_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rnd_valid <= valid_nx;
        end
    end

    assign warming = (state == ST_WARMUP);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        localparam logic [31:0] LANE_IDX = 32'(i);

        logic [31:0] s_q;
        logic [31:0] s_nx;
        logic [31:0] out_q;

        xorshift32_next u_next (
            .x (s_q),
            .y (s_nx)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q   <= lane_seed(SEED, LANE_IDX);
                out_q <= 32'h0;
            end else if (seed_we) begin
                s_q   <= lane_seed(seed_in, LANE_IDX);
                out_q <= 32'h0;
            end else if (warming) begin
                s_q   <= s_nx;
            end else if (load) begin
                s_q   <= s_nx;
                out_q <= s_nx;
            end
        end

        assign rnd_out[32*i +: 32] = out_q;
    end

endmodule

// File: tb/tb_xorshift_rng_bank.sv
// Directed and randomised-backpressure bench for two bank configurations:
// defaults (4 lanes, WARMUP=4) and a single lane with SEED=1, WARMUP=1.
module tb_xorshift_rng_bank;

    localparam int          LANES_A = 4;
    localparam logic [31:0] SEED_A  = 32'h8e20a6e5;
    localparam int          WARM_A  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   seed_we;
    logic [31:0]            seed_in;
    logic                   ready_a;
    logic                   ready_b;
    logic                   valid_a;
    logic                   valid_b;
    logic [32*LANES_A-1:0]  out_a;
    logic [31:0]            out_b;
    logic                   warming_a;
    logic                   warming_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_a [LANES_A];

    always #5 clk = ~clk;

    xorshift_rng_bank dut_a (
        .clk       (clk),
        .rst       (rst),
        .seed_we   (seed_we),
        .seed_in   (seed_in),
        .rnd_ready (ready_a),
        .rnd_valid (valid_a),
        .rnd_out   (out_a),
        .warming   (warming_a)
    );

    xorshift_rng_bank #(.N_LANES(1), .SEED(32'h0000_0001), .WARMUP(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .seed_we   (seed_we),
        .seed_in   (seed_in),
        .rnd_ready (ready_b),
        .rnd_valid (valid_b),
        .rnd_out   (out_b),
        .warming   (warming_b)
    );

    function automatic logic [31:0] m_step(input logic [31:0] x);
        logic [31:0] t;
        t = x;
        t = t ^ {t[18:0], 13'b0};
        t = t ^ {17'b0, t[31:17]};
        t = t ^ {t[26:0], 5'b0};
        return t;
    endfunction

    function automatic logic [31:0] m_pow(input logic [31:0] x, input int n);
        logic [31:0] t;
        t = x;
        for (int k = 0; k < n; k++) t = m_step(t);
        return t;
    endfunction

    function automatic logic [31:0] m_seed(input logic [31:0] b, input int i);
        logic [31:0] m;
        m = 32'h0;
        for (int k = 0; k < i; k++) m = m + 32'h9E3779B9;
        m = m ^ b;
        if (m == 32'h0) m = 32'h1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp_a(input logic [31:0] base);
        for (int i = 0; i < LANES_A; i++) exp_a[i] = m_pow(m_seed(base, i), WARM_A + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; seed_we = 1'b0; seed_in = 32'h0; ready_a = 1'b0; ready_b = 1'b0;
        #2;
        n_checks++;
        if (valid_a !== 1'b0 || out_a !== '0 || warming_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_a: valid=%b out=%h warming=%b, want 0/0/1", valid_a, out_a, warming_a);
        end
        tick();
        n_checks++;
        if (valid_b !== 1'b0 || out_b !== 32'h0 || warming_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b: valid=%b out=%h warming=%b, want 0/0/1", valid_b, out_b, warming_b);
        end
    endtask

    // Releases rst and checks the start-up sequence of both banks.
    task automatic test_first_words(input string tag);
        ready_a = 1'b0;
        ready_b = 1'b1;
        rst     = 1'b0;
        for (int k = 1; k <= WARM_A + 1; k++) begin
            tick();
            n_checks++;
            if (valid_a !== (k >= WARM_A + 1) || warming_a !== (k < WARM_A)) begin
                n_fail++;
                $display("FAIL %s_timing_a edge %0d: valid=%b warming=%b", tag, k, valid_a, warming_a);
            end
            n_checks++;
            if (valid_b !== (k >= 2) || warming_b !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_timing_b edge %0d: valid=%b warming=%b", tag, k, valid_b, warming_b);
            end
            if (k == 2) begin
                n_checks++;
                if (out_b !== 32'h0408_0601) begin
                    n_fail++;
                    $display("FAIL %s_word0_b: got %h want 04080601", tag, out_b);
                end
            end
            if (k == 3) begin
                n_checks++;
                if (out_b !== 32'h9DCC_A8C5) begin
                    n_fail++;
                    $display("FAIL %s_word1_b: got %h want 9dcca8c5", tag, out_b);
                end
            end
            if (k >= 4) begin
                n_checks++;
                if (out_b !== m_pow(32'h1, k)) begin
                    n_fail++;
                    $display("FAIL %s_wordn_b edge %0d: got %h want %h", tag, k, out_b, m_pow(32'h1, k));
                end
            end
        end
        load_exp_a(SEED_A);
        for (int i = 0; i < LANES_A; i++) begin
            n_checks++;
            if (out_a[32*i +: 32] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL %s_word0_a lane %0d: got %h want %h", tag, i, out_a[32*i +: 32], exp_a[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        ready_a = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (valid_a !== 1'b1 || out_a !== {exp_a[3], exp_a[2], exp_a[1], exp_a[0]}) begin
                n_fail++;
                $display("FAIL hold cycle %0d: valid=%b out=%h", c, valid_a, out_a);
            end
        end
        ready_a = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int i = 0; i < LANES_A; i++) exp_a[i] = m_step(exp_a[i]);
            n_checks++;
            if (valid_a !== 1'b1 || out_a !== {exp_a[3], exp_a[2], exp_a[1], exp_a[0]}) begin
                n_fail++;
                $display("FAIL stream word %0d: valid=%b out=%h", c, valid_a, out_a);
            end
        end
        ready_a = 1'b0;
    endtask

    task automatic test_reseed_zero();
        seed_in = 32'h0;
        seed_we = 1'b1;
        tick();
        seed_we = 1'b0;
        n_checks++;
        if (valid_a !== 1'b0 || warming_a !== 1'b1 || out_a !== '0 ||
            valid_b !== 1'b0 || warming_b !== 1'b1 || out_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reseed0_clear: va=%b wa=%b oa=%h vb=%b wb=%b ob=%h",
                     valid_a, warming_a, out_a, valid_b, warming_b, out_b);
        end
        for (int k = 1; k <= WARM_A + 1; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if (valid_b !== 1'b0 || warming_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reseed0_b_warm: valid=%b warming=%b want 0/0", valid_b, warming_b);
                end
            end
            if (k == 2) begin
                n_checks++;
                if (valid_b !== 1'b1 || out_b !== 32'h0408_0601) begin
                    n_fail++;
                    $display("FAIL reseed0_b_word: valid=%b out=%h want 1/04080601", valid_b, out_b);
                end
            end
        end
        load_exp_a(32'h0);
        n_checks++;
        if (valid_a !== 1'b1 || out_a !== {exp_a[3], exp_a[2], exp_a[1], exp_a[0]}) begin
            n_fail++;
            $display("FAIL reseed0_a_word: valid=%b out=%h", valid_a, out_a);
        end
    endtask

    task automatic test_reseed_held();
        logic [31:0] seeds [3];
        seeds[0] = 32'h1234_5678; seeds[1] = 32'hCAFE_F00D; seeds[2] = 32'h0BAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            seed_in = seeds[c];
            seed_we = 1'b1;
            tick();
            n_checks++;
            if (valid_a !== 1'b0 || warming_a !== 1'b1) begin
                n_fail++;
                $display("FAIL held_strobe %0d: valid=%b warming=%b want 0/1", c, valid_a, warming_a);
            end
        end
        seed_we = 1'b0;
        for (int k = 1; k <= WARM_A + 1; k++) begin
            tick();
            n_checks++;
            if (valid_a !== (k >= WARM_A + 1) || warming_a !== (k < WARM_A)) begin
                n_fail++;
                $display("FAIL held_timing edge %0d: valid=%b warming=%b", k, valid_a, warming_a);
            end
        end
        load_exp_a(seeds[2]);
        n_checks++;
        if (out_a !== {exp_a[3], exp_a[2], exp_a[1], exp_a[0]}) begin
            n_fail++;
            $display("FAIL held_word: got %h want %h", out_a, {exp_a[3], exp_a[2], exp_a[1], exp_a[0]});
        end
    endtask

    task automatic test_reseed_with_transfer();
        int warm_samples;
        n_checks++;
        if (valid_a !== 1'b1 || out_a !== {exp_a[3], exp_a[2], exp_a[1], exp_a[0]}) begin
            n_fail++;
            $display("FAIL xfer_word: valid=%b out=%h", valid_a, out_a);
        end
        ready_a = 1'b1;
        seed_in = 32'h5A5A_0001;
        seed_we = 1'b1;
        tick();
        seed_we = 1'b0;
        warm_samples = 0;
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL xfer_valid_drop: valid=%b want 0", valid_a);
        end
        if (warming_a === 1'b1) warm_samples++;
        for (int k = 1; k <= WARM_A + 1; k++) begin
            tick();
            if (warming_a === 1'b1) warm_samples++;
            n_checks++;
            if (valid_a !== (k >= WARM_A + 1)) begin
                n_fail++;
                $display("FAIL xfer_valid edge %0d: valid=%b", k, valid_a);
            end
        end
        ready_a = 1'b0;
        n_checks++;
        if (warm_samples != WARM_A) begin
            n_fail++;
            $display("FAIL xfer_warm_len: got %0d cycles want %0d", warm_samples, WARM_A);
        end
        load_exp_a(32'h5A5A_0001);
        n_checks++;
        if (out_a !== {exp_a[3], exp_a[2], exp_a[1], exp_a[0]}) begin
            n_fail++;
            $display("FAIL xfer_new_word: got %h want %h", out_a, {exp_a[3], exp_a[2], exp_a[1], exp_a[0]});
        end
    endtask

    task automatic test_async_reset();
        ready_a = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (valid_a !== 1'b0 || out_a !== '0 || warming_a !== 1'b1 ||
            valid_b !== 1'b0 || out_b !== 32'h0 || warming_b !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: va=%b oa=%h wa=%b vb=%b ob=%h wb=%b",
                     valid_a, out_a, warming_a, valid_b, out_b, warming_b);
        end
        tick();
        test_first_words("rerst");
    endtask

    task automatic test_random();
        int xfers;
        xfers = 0;
        for (int c = 0; c < 10000; c++) begin
            ready_a = 1'($urandom_range(0, 1));
            if (valid_a === 1'b1 && ready_a) begin
                for (int i = 0; i < LANES_A; i++) begin
                    n_checks++;
                    if (out_a[32*i +: 32] !== exp_a[i] || out_a[32*i +: 32] === 32'h0) begin
                        n_fail++;
                        $display("FAIL random xfer %0d lane %0d: got %h want %h",
                                 xfers, i, out_a[32*i +: 32], exp_a[i]);
                    end
                    exp_a[i] = m_step(exp_a[i]);
                end
                xfers++;
            end
            tick();
        end
        ready_a = 1'b0;
        n_checks++;
        if (xfers < 2000) begin
            n_fail++;
            $display("FAIL random_throughput: %0d transfers, want at least 2000", xfers);
        end
    endtask

    initial begin
        test_reset();
        test_first_words("powerup");
        test_backpressure();
        test_reseed_zero();
        test_reseed_held();
        test_reseed_with_transfer();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
